fifo_n: RTL
===========

FIFO_N -- requirements
Module: fifo_n

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  synchronous clear of all entries.
REQ-008 data_in  in  WIDTH  write data.
REQ-009 enable_in  in  1  producer valid; word transferred when enable_in && ready_out.
REQ-010 ready_out  out  1  FIFO can accept a word.
REQ-011 data_out  out  WIDTH  head-of-queue word.
REQ-012 enable_out  out  1  head word valid; transferred when enable_out && ready_in.
REQ-013 ready_in  in  1  consumer ready.
REQ-014 count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-015 almost_full  out  1  count >= AF_LEVEL.
REQ-016 almost_empty  out  1  count <= AE_LEVEL.

Function
REQ-017 push = enable_in && ready_out; pop = enable_out && ready_in.
REQ-018 Storage: DEPTH x WIDTH array, write pointer and read pointer each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-019 Push: write data_in at wr_ptr, wr_ptr+1; pop: rd_ptr+1.
REQ-020 count next = count + push - pop; push and pop in same cycle leave count unchanged.
REQ-021 ready_out = (count != DEPTH); enable_out = (count != 0); both decoded from registered count, no combinational path from enable_in or ready_in.
REQ-022 data_out = array[rd_ptr] when count != 0, else all zeros.
REQ-023 First-word latency: word pushed in cycle N appears on data_out with enable_out=1 in cycle N+1; no empty-bypass.
REQ-024 Full (count==DEPTH): ready_out=0, enable_in ignored, no overwrite even if pop occurs that cycle; ready_out returns 1 the cycle after a pop.
REQ-025 Empty (count==0): enable_out=0, ready_in ignored, no pointer movement.
REQ-026 Simultaneous push and pop at 0<count<DEPTH: both performed, order preserved.
REQ-027 Strict FIFO ordering; no word lost, duplicated or reordered across pointer wrap-around.
REQ-028 data_out and enable_out stable while enable_out=1 and ready_in=0.
REQ-029 flush=1: next edge sets count=0, wr_ptr=rd_ptr=0; flush overrides push and pop in that cycle.
REQ-030 almost_full and almost_empty combinational from registered count only.

Reset
REQ-031 reset_n low asynchronously forces count=0, wr_ptr=0, rd_ptr=0 regardless of clk.
REQ-032 During and after reset: ready_out=1, enable_out=0, data_out=0, count=0, almost_full=0, almost_empty=1.
REQ-033 Array contents not reset; unreadable while count=0.
REQ-034 Reset asserted mid-transfer discards all stored words; first push after release accepted on first rising edge with reset_n high.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 Reset then idle -> ready_out=1, enable_out=0, data_out=0x00, count=0, almost_empty=1.
REQ-036 Push 0x11,0x22,0x33,0x44 with ready_in=0 -> count 1,2,3,4; almost_full at count 3; ready_out=0 at count 4; fifth push 0x55 ignored; then drain -> 0x11,0x22,0x33,0x44 in order, enable_out=0 after.
REQ-037 Full, enable_in=1 and ready_in=1 same cycle -> pop of head only, count 4->3, next cycle ready_out=1.
REQ-038 count=2, continuous push and pop for 10 cycles with incrementing data -> count stays 2, output sequence continuous across wrap, no gaps.
REQ-039 count=3, assert flush with enable_in=1 -> next cycle count=0, enable_out=0, data_out=0x00, pushed word not stored.
REQ-040 count=2, pulse reset_n low between clock edges -> outputs reach reset values immediately, before next edge.

Source files
------------

// File: rtl/fifo_n_if.sv
// Handshake bundle for fifo_n: producer side, consumer side, flush and occupancy status.
interface fifo_n_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     flush;
  logic [WIDTH-1:0]         data_in;
  logic                     enable_in;
  logic                     ready_out;
  logic [WIDTH-1:0]         data_out;
  logic                     enable_out;
  logic                     ready_in;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;
  logic                     almost_empty;

  modport master (
    output flush, data_in, enable_in, ready_in,
    input  ready_out, data_out, enable_out, count, almost_full, almost_empty
  );

  modport slave (
    input  flush, data_in, enable_in, ready_in,
    output ready_out, data_out, enable_out, count, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_n.sv
// Synchronous FIFO with valid/ready on both sides, registered occupancy count and almost flags.
// No empty bypass: a pushed word becomes visible on the cycle after it is written.
module fifo_n #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic    clk,
  input logic    reset_n,
  fifo_n_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on the registered count, never on enable_in/ready_in.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.enable_in && !full;
  assign pop   = bus.ready_in && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.ready_out    = !full;
  assign bus.enable_out   = !empty;
  assign bus.data_out     = empty ? '0 : mem[rd_ptr];
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
endmodule
